// File: rtl/spram_stream_fifo_if.sv
// Signal bundle for spram_stream_fifo: upstream stream, downstream stream,
// occupancy and the port set of the external single-port RAM.
interface spram_stream_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] ram_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  // FIFO controller side.
  modport slave (
    input  in_data, in_valid, out_ready, ram_q,
    output in_ready, out_data, out_valid, count, ram_data, ram_addr, ram_we
  );

  // Environment side: stream source/sink plus the RAM itself.
  modport master (
    output in_data, in_valid, out_ready, ram_q,
    input  in_ready, out_data, out_valid, count, ram_data, ram_addr, ram_we
  );
endinterface

// File: rtl/spram_stream_fifo.sv
// Valid/ready FIFO built on an external single-port RAM with registered read
// address; one RAM op per cycle, 2-entry output buffer hides the read latency.
module spram_stream_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spram_stream_fifo_if.slave   bus
);

  localparam logic [ADDR_W:0]   RAM_DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } ram_op_e;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  logic [ADDR_W:0]   ram_cnt_nxt;
  logic              rd_pend;
  logic              last_wr;
  logic              alive;
  logic [1:0]        ob_cnt;
  logic [1:0]        ob_cnt_nxt;
  logic [DATA_W-1:0] ob_head;
  logic [DATA_W-1:0] ob_tail;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_nxt;

  logic    read_pref;
  logic    in_ready_int;
  logic    out_valid_int;
  logic    pop;
  ram_op_e op;

  // Decisions use registered state only, so neither handshake input can
  // reach the opposite side's ready/valid combinationally.
  assign read_pref     = (ram_cnt != '0) &&
                         (({1'b0, ob_cnt} + {2'b00, rd_pend}) < 3'd2);
  assign in_ready_int  = alive && (ram_cnt < RAM_DEPTH) && !(read_pref && last_wr);
  assign out_valid_int = (ob_cnt != 2'd0);
  assign pop           = out_valid_int && bus.out_ready;

  // NOTE: every variable assigned in an always_comb gets a default first;
  // otherwise a missed branch infers a latch.
  always_comb begin
    op = OP_IDLE;
    if (bus.in_valid && in_ready_int) begin
      op = OP_WRITE;
    end else if (read_pref) begin
      op = OP_READ;
    end
  end

  always_comb begin
    ram_cnt_nxt = ram_cnt;
    ob_cnt_nxt  = ob_cnt;
    case (op)
      OP_WRITE: ram_cnt_nxt = ram_cnt + CNT_ONE;
      OP_READ:  ram_cnt_nxt = ram_cnt - CNT_ONE;
      default:  ;
    endcase
    case ({rd_pend, pop})
      2'b10:   ob_cnt_nxt = ob_cnt + 2'd1;
      2'b01:   ob_cnt_nxt = ob_cnt - 2'd1;
      default: ;
    endcase
    count_nxt = ram_cnt_nxt
              + {{ADDR_W{1'b0}}, (op == OP_READ)}
              + {{(ADDR_W-1){1'b0}}, ob_cnt_nxt};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
      last_wr <= 1'b0;
      ob_cnt  <= 2'd0;
      count_q <= '0;
    end else begin
      alive   <= 1'b1;
      ram_cnt <= ram_cnt_nxt;
      ob_cnt  <= ob_cnt_nxt;
      count_q <= count_nxt;
      rd_pend <= (op == OP_READ);
      case (op)
        OP_WRITE: begin
          wr_ptr  <= wr_ptr + PTR_ONE;
          last_wr <= 1'b1;
        end
        OP_READ: begin
          rd_ptr  <= rd_ptr + PTR_ONE;
          last_wr <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the two buffer words are reset (unlike the RAM) because the head
  // drives out_data, which must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob_head <= '0;
      ob_tail <= '0;
    end else if (pop) begin
      if (rd_pend && (ob_cnt == 2'd1)) begin
        ob_head <= bus.ram_q;
      end else begin
        ob_head <= ob_tail;
      end
      if (rd_pend && (ob_cnt == 2'd2)) begin
        ob_tail <= bus.ram_q;
      end
    end else if (rd_pend) begin
      if (ob_cnt == 2'd0) begin
        ob_head <= bus.ram_q;
      end else begin
        ob_tail <= bus.ram_q;
      end
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.out_data  = ob_head;
  assign bus.count     = count_q;

  // Idle cycles park the address on rd_ptr; write data is held at zero until
  // the block is alive so the RAM port shows its reset values.
  assign bus.ram_we   = (op == OP_WRITE);
  assign bus.ram_addr = (op == OP_WRITE) ? wr_ptr : rd_ptr;
  assign bus.ram_data = alive ? bus.in_data : '0;

endmodule

// File: tb/tb_spram_stream_fifo.sv
// Self-checking bench for spram_stream_fifo: cycle table for reset/first word,
// scoreboard on every handshake, directed fill/wrap/arbitration/reset runs.
module tb_spram_stream_fifo;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;

  logic clk;
  logic rst_n;

  spram_stream_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  spram_stream_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // External RAM model: registered address, combinational read data.
  logic [DATA_W-1:0] ram_mem [64];
  logic [ADDR_W-1:0] ram_addr_q;

  always @(posedge clk) begin
    ram_addr_q <= bus.ram_addr;
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_data;
  end
  assign bus.ram_q = ram_mem[ram_addr_q];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Scoreboard: push on accepted input, pop and compare on accepted output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          fail("sb_unexpected_output");
        end else begin
          check("sb_data", {24'd0, bus.out_data}, {24'd0, sb.pop_front()});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) fail("push_timeout");
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    while ((bus.count != 0 || bus.out_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_count", {25'd0, bus.count}, 32'd0);
    check("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("drain_sb_empty", sb.size(), 32'd0);
    step();
    bus.out_ready = 1'b0;
  endtask

  typedef struct {
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       exp_in_ready;
    logic       exp_out_valid;
    logic [6:0] exp_count;
    logic       exp_ram_we;
    logic       chk_data;
    logic [7:0] exp_out_data;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int sent;
    int cyc;
    logic fire;
    logic prev_we;
    logic [7:0] nxt;

    // Period after edge k after reset release; A5 accepted at the 2nd edge.
    //            iv    din    ordy  irdy  ovld  cnt   we    chk   dout
    vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 8'h00};
    vecs[1] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 7'd0, 1'b1, 1'b1, 8'h00};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd1, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd1, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 7'd1, 1'b0, 1'b1, 8'hA5};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 8'h00};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h5A;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, bus.out_data},  32'd0);
    check("rst_count",     {25'd0, bus.count},     32'd0);
    check("rst_ram_we",    {31'd0, bus.ram_we},    32'd0);
    check("rst_ram_addr",  {26'd0, bus.ram_addr},  32'd0);
    check("rst_ram_data",  {24'd0, bus.ram_data},  32'd0);
    rst_n = 1'b1;

    // First word, cycle by cycle
    for (int i = 0; i < 6; i++) begin
      bus.in_valid  = vecs[i].in_valid;
      bus.in_data   = vecs[i].in_data;
      bus.out_ready = vecs[i].out_ready;
      @(negedge clk);
      check($sformatf("v%0d_in_ready", i),  {31'd0, bus.in_ready},  {31'd0, vecs[i].exp_in_ready});
      check($sformatf("v%0d_out_valid", i), {31'd0, bus.out_valid}, {31'd0, vecs[i].exp_out_valid});
      check($sformatf("v%0d_count", i),     {25'd0, bus.count},     {25'd0, vecs[i].exp_count});
      check($sformatf("v%0d_ram_we", i),    {31'd0, bus.ram_we},    {31'd0, vecs[i].exp_ram_we});
      if (vecs[i].chk_data)
        check($sformatf("v%0d_out_data", i), {24'd0, bus.out_data}, {24'd0, vecs[i].exp_out_data});
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Fill to 66 with output stalled
    for (int i = 0; i < 66; i++) push_word(8'(i));
    repeat (3) step();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    @(negedge clk);
    check("full_count",     {25'd0, bus.count},     32'd66);
    check("full_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("full_out_valid", {31'd0, bus.out_valid}, 32'd1);

    // Pop at 66 while input is offered
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("pop66_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("pop66_count",    {25'd0, bus.count},    32'd66);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("pop66_count_a", {25'd0, bus.count},    32'd65);
    check("pop66_in_rdy_a",{31'd0, bus.in_ready}, 32'd0);
    check("pop66_read",    {31'd0, bus.ram_we},   32'd0);
    step();
    @(negedge clk);
    check("pop66_count_b", {25'd0, bus.count},     32'd65);
    check("pop66_ovalid",  {31'd0, bus.out_valid}, 32'd1);
    step();
    drain();

    // Pointer wrap with random handshakes
    sent = 0;
    cyc  = 0;
    while (sent < 200 && cyc < 8000) begin
      bus.in_valid  = $urandom_range(0, 2) != 0;
      bus.in_data   = 8'(sent);
      bus.out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready;
      step();
      if (fire) sent++;
      cyc++;
    end
    if (sent < 200) fail("wrap_timeout");
    drain();

    // Arbitration: RAM kept non-empty, both sides active
    for (int i = 0; i < 10; i++) push_word(8'hB0 + 8'(i));
    nxt           = 8'hC0;
    bus.out_ready = 1'b1;
    prev_we       = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = nxt;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) nxt = nxt + 8'd1;
      if (k >= 2) check($sformatf("arb_alt_%0d", k), {31'd0, bus.ram_we}, {31'd0, ~prev_we});
      prev_we = bus.ram_we;
      step();
    end
    drain();

    // Mid-operation reset
    for (int i = 0; i < 10; i++) push_word(8'hD0 + 8'(i));
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mrst_count",     {25'd0, bus.count},     32'd0);
    check("mrst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    push_word(8'h3C);
    push_word(8'h3D);
    cyc = 0;
    @(negedge clk);
    while (!bus.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("mrst_first_word", {24'd0, bus.out_data}, 32'h3C);
    step();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
